mem_responder: RTL and testbench

//   Memory-side responder for the 8-bit CPU bus (mar/mbr/we). Holds the 256x8

---
 rtl/up1_pkg.sv | 24 ++
 rtl/mem_responder_if.sv | 39 +++
 rtl/mem_responder_video_scanner.sv | 101 ++++++++++
 rtl/mem_responder.sv | 96 +++++++++
 tb/tb_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/up1_pkg.sv
// Shared constants and types for the 8-bit CPU memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: default bus widths, memory map bases, video geometry and the
// scanner state type.
package up1_pkg;

  localparam int UP1_ADDR_W    = 8;
  localparam int UP1_DATA_W    = 8;
  localparam int UP1_VID_BASE  = 8'h80;
  localparam int UP1_VID_CELLS = 80;
  localparam int UP1_VID_COLS  = 8;
  localparam int UP1_DATA_BASE = 8'hF0;

  // Cell index width: enough for 0..VID_CELLS-1.
  localparam int UP1_IDX_W     = 7;

  typedef enum logic {
    SCAN_LOAD,
    SCAN_SHOW
  } scan_state_t;

endpackage : up1_pkg

// File: rtl/mem_responder_if.sv
// Video cell stream from the memory responder to the display path.
// Latency: n/a (wires only).
// Backpressure: cell fields are held stable while vid_valid && !vid_ready.
//
// Signals:
//   vid_data  cell value           vid_idx  cell index 0..VID_CELLS-1
//   vid_valid cell fields valid    vid_ready display accepts the cell
//   vid_sof   index 0              vid_eol  last cell of a display row
// Modports: master = responder side, slave = display side.
interface mem_responder_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] vid_data;
  logic [6:0]        vid_idx;
  logic              vid_valid;
  logic              vid_ready;
  logic              vid_sof;
  logic              vid_eol;

  modport master (
    output vid_data,
    output vid_idx,
    output vid_valid,
    output vid_sof,
    output vid_eol,
    input  vid_ready
  );

  modport slave (
    input  vid_data,
    input  vid_idx,
    input  vid_valid,
    input  vid_sof,
    input  vid_eol,
    output vid_ready
  );

endinterface : mem_responder_if

// File: rtl/mem_responder_video_scanner.sv
// Walks the video area one cell at a time and presents each cell on the stream.
// Latency: one LOAD clock per cell, so 2 clocks per cell with vid_ready high.
// Backpressure: holds the presented cell until vid_valid && vid_ready.
//
// Ports:
//   clock, reset       system clock, async active-low reset
//   o_rd_addr          address into the memory's second read port
//   i_rd_data          data from that read port (combinational)
//   vid                video stream (master side)
module video_scanner
  import up1_pkg::*;
#(
  parameter int ADDR_W    = UP1_ADDR_W,
  parameter int DATA_W    = UP1_DATA_W,
  parameter int VID_BASE  = UP1_VID_BASE,
  parameter int VID_CELLS = UP1_VID_CELLS,
  parameter int VID_COLS  = UP1_VID_COLS
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  mem_responder_if.master   vid
);

  scan_state_t r_state;
  scan_state_t w_next_state;

  logic [UP1_IDX_W-1:0] r_idx;
  logic [DATA_W-1:0]    r_data;
  logic                 r_valid;
  logic                 r_sof;
  logic                 r_eol;

  logic w_load;
  logic w_accept;
  logic w_last;
  logic w_eol_dec;

  assign w_accept  = r_valid && vid.vid_ready;
  assign w_last    = (r_idx == UP1_IDX_W'(VID_CELLS - 1));
  assign w_eol_dec = ((int'(r_idx) % VID_COLS) == (VID_COLS - 1));

  // The read address follows the index; the LOAD edge samples the cell,
  // so a CPU write on that same edge is not seen (read-before-write).
  assign o_rd_addr = ADDR_W'(VID_BASE) + ADDR_W'(r_idx);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= SCAN_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      SCAN_LOAD: begin
        w_load       = 1'b1;
        w_next_state = SCAN_SHOW;
      end
      SCAN_SHOW: begin
        if (w_accept) begin
          w_next_state = SCAN_LOAD;
        end
      end
      default: begin
        w_next_state = SCAN_LOAD;
      end
    endcase
  end

  // Output registers. The cell value is a snapshot taken at LOAD, so CPU
  // writes while the cell is on show only appear on its next visit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
    end else if (w_load) begin
      r_data  <= i_rd_data;
      r_valid <= 1'b1;
      r_sof   <= (r_idx == '0);
      r_eol   <= w_eol_dec;
    end else if (w_accept) begin
      r_valid <= 1'b0;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  assign vid.vid_data  = r_data;
  assign vid.vid_idx   = r_idx;
  assign vid.vid_valid = r_valid;
  assign vid.vid_sof   = r_sof;
  assign vid.vid_eol   = r_eol;

endmodule : video_scanner

// File: rtl/mem_responder.sv
// Memory-side responder for the 8-bit CPU bus: 256x8 unified memory with a
// combinational CPU read, clocked CPU write and a video-area stream.
// Latency: CPU read 0 clocks, CPU write visible next clock, video 2 clocks/cell.
// Backpressure: video cell held until vid_ready; the CPU port never stalls.
//
// Ports:
//   clock, reset  system clock, async active-low reset (memory not cleared)
//   mar           CPU address
//   mbr           CPU data, driven here only while we==0
//   we            CPU write enable (CPU drives mbr while high)
//   vid           video cell stream (master side)
//   wr_fault      sticky flag: write into the program area was discarded
// Build option: define ROM_PROTECT_EN to make addresses below the video area
// read-only and enable wr_fault; otherwise everything is writable and
// wr_fault is 0.
module mem_responder
  import up1_pkg::*;
#(
  parameter int    ADDR_W    = UP1_ADDR_W,
  parameter int    DATA_W    = UP1_DATA_W,
  parameter int    VID_BASE  = UP1_VID_BASE,
  parameter int    VID_CELLS = UP1_VID_CELLS,
  parameter int    VID_COLS  = UP1_VID_COLS,
  parameter string INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mar,
  inout  wire  [DATA_W-1:0] mbr,
  input  logic              we,
  mem_responder_if.master   vid,
  output logic              wr_fault
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] w_rd_data;
  logic [ADDR_W-1:0] w_scan_addr;
  logic [DATA_W-1:0] w_scan_data;
  logic              w_wr_allow;

  // Power-up image only; reset deliberately leaves the contents alone.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      r_mem[i] = '0;
    end
  end

  assign w_rd_data   = r_mem[mar];
  assign w_scan_data = r_mem[w_scan_addr];

  // Release the bus whenever the CPU is writing.
  assign mbr = we ? {DATA_W{1'bz}} : w_rd_data;

`ifdef ROM_PROTECT_EN
  logic r_wr_fault;

  assign w_wr_allow = (mar >= ADDR_W'(VID_BASE));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_fault <= 1'b0;
    end else if (we && !w_wr_allow) begin
      r_wr_fault <= 1'b1;
    end
  end

  assign wr_fault = r_wr_fault;
`else
  assign w_wr_allow = 1'b1;
  assign wr_fault   = 1'b0;
`endif

  always @(posedge clock) begin
    if (we && w_wr_allow) begin
      r_mem[mar] <= mbr;
    end
  end

  video_scanner #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .VID_BASE  (VID_BASE),
    .VID_CELLS (VID_CELLS),
    .VID_COLS  (VID_COLS)
  ) u_scanner (
    .clock     (clock),
    .reset     (reset),
    .o_rd_addr (w_scan_addr),
    .i_rd_data (w_scan_data),
    .vid       (vid)
  );

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: randomized CPU traffic and video
// backpressure, with a queue of expected video cells drained by a monitor.
// Expected cells come from a plain array model of memory and the frame rules.
module tb_mem_responder;

  typedef struct {
    logic [7:0] data;
    int         idx;
    bit         sof;
    bit         eol;
  } cell_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] mar   = 8'h00;
  logic       we    = 1'b0;
  logic [7:0] wdata = 8'h00;
  wire  [7:0] mbr;
  logic       wr_fault;

  logic [7:0] model [256];
  cell_t      exp_q [$];
  int         gen_idx   = 0;
  int         chk_cnt   = 0;
  int         pass_cnt  = 0;
  bit         rdy_mode  = 1'b0;
  bit         stall_at3 = 1'b0;
  int         cnt3      = 0;
  logic [7:0] last3     = 8'h00;

  assign mbr = we ? wdata : 8'hzz;

  mem_responder_if #(.DATA_W(8)) vif ();

  mem_responder #(.INIT_FILE("")) dut (
    .clock    (clock),
    .reset    (reset),
    .mar      (mar),
    .mbr      (mbr),
    .we       (we),
    .vid      (vif),
    .wr_fault (wr_fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit writable(input logic [7:0] a);
`ifdef ROM_PROTECT_EN
    return a >= 8'h80;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] rand_nonvideo();
`ifdef ROM_PROTECT_EN
    return 8'($urandom_range(8'hD0, 8'hFF));
`else
    if ($urandom_range(0, 1) == 0) return 8'($urandom_range(8'h00, 8'h7F));
    return 8'($urandom_range(8'hD0, 8'hFF));
`endif
  endfunction

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    mar   = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clock);
    #1;
    we = 1'b0;
    if (writable(a)) model[a] = d;
  endtask

  task automatic cpu_read_check(input string nm, input logic [7:0] a);
    @(negedge clock);
    mar = a;
    #1;
    check(nm, int'(mbr), int'(model[a]));
  endtask

  // Expected-cell generator: keeps a few cells queued ahead, taken from the
  // memory model at the time they are queued.
  initial begin
    cell_t c;
    forever begin
      @(posedge clock);
      #3;
      if (!reset) begin
        exp_q.delete();
        gen_idx = 0;
      end else begin
        while (exp_q.size() < 4) begin
          c.idx  = gen_idx;
          c.data = model[8'h80 + gen_idx];
          c.sof  = (gen_idx == 0);
          c.eol  = ((gen_idx % 8) == 7);
          exp_q.push_back(c);
          gen_idx = (gen_idx + 1) % 80;
        end
      end
    end
  end

  // Display-side ready driver.
  initial begin
    vif.vid_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      if (stall_at3 && vif.vid_valid && vif.vid_idx == 7'd3) vif.vid_ready = 1'b0;
      else if (rdy_mode) vif.vid_ready = 1'b1;
      else vif.vid_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: every cell that will be accepted on the coming edge.
  initial begin
    cell_t c;
    forever begin
      @(negedge clock);
      if (reset && vif.vid_valid && vif.vid_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          c = exp_q.pop_front();
          check("sb_idx",  int'(vif.vid_idx),  c.idx);
          check("sb_data", int'(vif.vid_data), int'(c.data));
          check("sb_sof",  int'(vif.vid_sof),  int'(c.sof));
          check("sb_eol",  int'(vif.vid_eol),  int'(c.eol));
          if (vif.vid_idx == 7'd3) begin
            last3 = vif.vid_data;
            cnt3++;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    bit         prev_valid;
    int         prev_idx;
    int         last_sof_cyc;
    int         c0;
    logic [7:0] held;
    logic [7:0] a;

    for (int i = 0; i < 256; i++) model[i] = 8'h00;

    // Fill memory while the scanner is held in reset.
    for (int i = 0; i < 256; i++) begin
      if (writable(8'(i))) cpu_write(8'(i), 8'($urandom));
    end

    @(posedge clock);
    #1;
    check("rst_valid", int'(vif.vid_valid), 0);
    check("rst_idx",   int'(vif.vid_idx),   0);
    check("rst_sof",   int'(vif.vid_sof),   0);
    check("rst_eol",   int'(vif.vid_eol),   0);
    check("rst_data",  int'(vif.vid_data),  0);
    check("rst_fault", int'(wr_fault),      0);

`ifndef ROM_PROTECT_EN
    cpu_write(8'h05, 8'h4F);
`endif
    cpu_read_check("read_05", 8'h05);
    cpu_write(8'hF3, 8'hA5);
    cpu_read_check("read_F3", 8'hF3);
    check("read_F3_val", int'(mbr), 8'hA5);
    for (int i = 0; i < 10; i++) cpu_read_check("read_rand", 8'($urandom));

    @(negedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rel_valid", int'(vif.vid_valid), 1);
    check("rel_idx",   int'(vif.vid_idx),   0);
    check("rel_sof",   int'(vif.vid_sof),   1);

    // Random CPU traffic outside the video area, random backpressure.
    for (int k = 0; k < 120; k++) begin
      a = rand_nonvideo();
      cpu_write(a, 8'($urandom));
      cpu_read_check("rw_rand", 8'($urandom));
    end
    repeat (200) @(posedge clock);

    // Ready held high: strict 2-clock cadence, 160-clock frame.
    rdy_mode = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    prev_valid   = vif.vid_valid;
    prev_idx     = -1;
    last_sof_cyc = -1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clock);
      #1;
      check("toggle", int'(vif.vid_valid), int'(!prev_valid));
      prev_valid = vif.vid_valid;
      if (vif.vid_valid) begin
        if (prev_idx >= 0) check("idx_step", int'(vif.vid_idx), (prev_idx + 1) % 80);
        prev_idx = int'(vif.vid_idx);
        check("sof_dec", int'(vif.vid_sof), int'(vif.vid_idx == 7'd0));
        check("eol_dec", int'(vif.vid_eol), int'((int'(vif.vid_idx) % 8) == 7));
        if (vif.vid_sof) begin
          if (last_sof_cyc >= 0) check("frame_len", cyc - last_sof_cyc, 160);
          last_sof_cyc = cyc;
        end
      end
    end
    rdy_mode = 1'b0;

    // Snapshot: stall on idx 3 and overwrite that cell underneath it.
    stall_at3 = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clock);
      if (vif.vid_valid && vif.vid_idx == 7'd3 && !vif.vid_ready) ok = 1'b1;
    end
    check("stall3_reached", int'(ok), 1);
    held = vif.vid_data;
    check("stall3_old", int'(held), int'(model[8'h83]));
    cpu_write(8'h83, 8'h77);
    for (int t = 0; t < 3; t++) begin
      @(posedge clock);
      #1;
      check("snap_data",  int'(vif.vid_data),  int'(held));
      check("snap_valid", int'(vif.vid_valid), 1);
    end
    cpu_read_check("read_83", 8'h83);
    c0 = cnt3;
    stall_at3 = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(posedge clock);
      if (cnt3 >= c0 + 2) ok = 1'b1;
    end
    check("next_frame_seen", int'(ok), 1);
    check("next_frame_77", int'(last3), 8'h77);

    // Reset mid-frame.
    ok = 1'b0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(posedge clock);
      #1;
      if (vif.vid_idx == 7'd40) ok = 1'b1;
    end
    check("idx40_reached", int'(ok), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", int'(vif.vid_valid), 0);
    check("mid_rst_idx",   int'(vif.vid_idx),   0);
    check("mid_rst_sof",   int'(vif.vid_sof),   0);
    check("mid_rst_eol",   int'(vif.vid_eol),   0);
    check("mid_rst_data",  int'(vif.vid_data),  0);
    repeat (3) @(posedge clock);
    for (int i = 0; i < 8; i++) cpu_read_check("keep_vid", 8'(8'h80 + $urandom_range(0, 79)));
    cpu_read_check("keep_F3", 8'hF3);
    @(negedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst2_valid", int'(vif.vid_valid), 1);
    check("rst2_idx",   int'(vif.vid_idx),   0);
    check("rst2_sof",   int'(vif.vid_sof),   1);

    // Program-area write.
    cpu_write(8'h10, 8'hFF);
    cpu_read_check("read_10", 8'h10);
`ifdef ROM_PROTECT_EN
    check("fault_set", int'(wr_fault), 1);
    cpu_write(8'hF0, 8'h3C);
    cpu_read_check("read_F0", 8'hF0);
    check("read_F0_val", int'(mbr), 8'h3C);
`else
    check("read_10_val", int'(mbr), 8'hFF);
    check("fault_zero", int'(wr_fault), 0);
`endif

    repeat (300) @(posedge clock);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_mem_responder
